// File: rtl/wb_arbiter_pkg.sv
// Shared constants and helpers for the write-back path and the issue-side hazard check.
package wb_arbiter_pkg;

    localparam int REG_ZERO = 0;

    // Index width for a table of n entries; never below one bit.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus encoded index, priority rotates past the winner.
// Latency: grant is combinational from req and the registered pointer.
// Backpressure: a grant means consumption; losers simply wait, the pointer only moves on a grant.
module rr_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter  int N  = 4,
    localparam int PW = addr_width(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          gnt_vld
);

    logic [PW-1:0] ptr;

    always_comb begin
        int c;
        c       = 0;
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int k = 0; k < N; k++) begin
            c = int'(ptr) + k;
            if (c >= N) c = c - N;
            if (!gnt_vld && req[c]) begin
                gnt[c]  = 1'b1;
                gnt_idx = PW'(c);
                gnt_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (gnt_vld) begin
            ptr <= (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter for the single regfile write port plus per-register busy scoreboard.
// Latency: grant in cycle N, rf_we/rf_waddr/rf_wdata registered for N+1; busy clears at end of N.
// Backpressure: req_ready is a combinational one-hot grant; ungranted requesters hold their request.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 64,
    parameter  int NREQ  = 4,
    localparam int AW    = addr_width(DEPTH),
    localparam int PW    = addr_width(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*AW-1:0]    req_reg,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  claim_valid,
    input  logic [AW-1:0]         claim_reg,
    output logic [DEPTH-1:0]      busy,
    output logic                  rf_we,
    output logic [AW-1:0]         rf_waddr,
    output logic [WIDTH-1:0]      rf_wdata
);

    logic [AW-1:0]    reg_a  [NREQ];
    logic [WIDTH-1:0] data_a [NREQ];
    logic [PW-1:0]    gnt_idx;
    logic             gnt_vld;
    logic [AW-1:0]    sel_reg;
    logic [WIDTH-1:0] sel_data;
    logic [DEPTH-1:0] busy_nxt;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign reg_a[i]  = req_reg[i*AW +: AW];
        assign data_a[i] = req_data[i*WIDTH +: WIDTH];
    end

    rr_arbiter #(.N(NREQ)) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .gnt     (req_ready),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign sel_reg  = reg_a[gnt_idx];
    assign sel_data = data_a[gnt_idx];

    // Claim is applied after the clear: a new producer supersedes the one writing back now.
    always_comb begin
        busy_nxt = busy;
        if (gnt_vld) busy_nxt[sel_reg] = 1'b0;
        if (claim_valid) busy_nxt[claim_reg] = 1'b1;
        busy_nxt[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // Writes to the zero register are consumed but never reach the regfile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= gnt_vld && (sel_reg != AW'(REG_ZERO));
            if (gnt_vld) begin
                rf_waddr <= sel_reg;
                rf_wdata <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Vector table plus hand sequences for wb_arbiter; write-port results checked through a scoreboard queue.
module tb_wb_arbiter;

    localparam int WIDTH = 16;
    localparam int DEPTH = 64;
    localparam int NREQ  = 4;
    localparam int AW    = 6;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*AW-1:0]    req_reg;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  claim_valid;
    logic [AW-1:0]         claim_reg;
    logic [DEPTH-1:0]      busy;
    logic                  rf_we;
    logic [AW-1:0]         rf_waddr;
    logic [WIDTH-1:0]      rf_wdata;

    wb_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_reg     (req_reg),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .claim_valid (claim_valid),
        .claim_reg   (claim_reg),
        .busy        (busy),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  v;
        logic [23:0] rg;
        logic [63:0] dt;
        logic        cv;
        logic [5:0]  cr;
        logic [3:0]  er;
    } vec_t;

    vec_t              tbl[$];
    logic [22:0]       sb_q[$];
    int                total = 0;
    int                bad   = 0;
    int                gcnt[4];
    logic [DEPTH-1:0]  busy_m;
    logic [AW-1:0]     last_addr;
    logic [WIDTH-1:0]  last_data;

    localparam logic [23:0] RG = {6'd13, 6'd12, 6'd11, 6'd10};

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    function automatic logic [63:0] mk_dt(input int k);
        logic [15:0] b;
        b = 16'(k);
        return {16'h3000 + b, 16'h2000 + b, 16'h1000 + b, 16'h0000 + b};
    endfunction

    // Drives one cycle of stimulus; grant checked combinationally, write port and busy after the edge.
    task automatic apply(input logic [3:0] v, input logic [23:0] rg, input logic [63:0] dt,
                         input logic cv, input logic [5:0] cr, input logic [3:0] er, input string nm);
        logic [DEPTH-1:0] nb;
        logic             e_we;
        logic [22:0]      exp_w;
        req_valid   = v;
        req_reg     = rg;
        req_data    = dt;
        claim_valid = cv;
        claim_reg   = cr;
        #1;
        chk({nm, " ready"}, 64'(req_ready), 64'(er));
        for (int i = 0; i < 4; i++) gcnt[i] += int'(req_ready[i]);
        nb   = busy_m;
        e_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (er[i]) begin
                last_addr = rg[i*6 +: 6];
                last_data = dt[i*16 +: 16];
                e_we      = (last_addr != 6'd0);
                nb[last_addr] = 1'b0;
            end
        end
        if (cv) nb[cr] = 1'b1;
        nb[0] = 1'b0;
        sb_q.push_back({e_we, last_addr, last_data});
        @(posedge clk);
        #1;
        exp_w = sb_q.pop_front();
        chk({nm, " wport"}, 64'({rf_we, rf_waddr, rf_wdata}), 64'(exp_w));
        chk({nm, " busy"}, 64'(busy), 64'(nb));
        busy_m = nb;
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid   = '0;
        req_reg     = '0;
        req_data    = '0;
        claim_valid = 1'b0;
        claim_reg   = '0;
        busy_m      = '0;
        last_addr   = '0;
        last_data   = '0;

        // Reset state
        #12;
        chk("rst rf_we", 64'(rf_we), 64'd0);
        chk("rst rf_waddr", 64'(rf_waddr), 64'd0);
        chk("rst rf_wdata", 64'(rf_wdata), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        req_valid = 4'b1111;
        #1;
        chk("rst ready all", 64'(req_ready), 64'b0001);
        req_valid = 4'b0010;
        #1;
        chk("rst ready one", 64'(req_ready), 64'b0010);
        req_valid = 4'b0000;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single request, idle, steer ptr to 0, fairness, pointer skip, reg 0, back-to-back claims
        tbl.push_back('{4'b0001, {6'd13, 6'd12, 6'd11, 6'd5}, {48'h0, 16'h1234}, 1'b1, 6'd10, 4'b0001});
        tbl.push_back('{4'b0000, RG, mk_dt(1), 1'b1, 6'd11, 4'b0000});
        tbl.push_back('{4'b1000, RG, mk_dt(2), 1'b1, 6'd12, 4'b1000});
        tbl.push_back('{4'b1111, RG, mk_dt(3), 1'b1, 6'd13, 4'b0001});
        tbl.push_back('{4'b1111, RG, mk_dt(4), 1'b0, 6'd0,  4'b0010});
        tbl.push_back('{4'b1111, RG, mk_dt(5), 1'b1, 6'd40, 4'b0100});
        tbl.push_back('{4'b1111, RG, mk_dt(6), 1'b0, 6'd0,  4'b1000});
        tbl.push_back('{4'b1111, RG, mk_dt(7), 1'b1, 6'd10, 4'b0001});
        tbl.push_back('{4'b1111, RG, mk_dt(8), 1'b0, 6'd0,  4'b0010});
        tbl.push_back('{4'b1111, RG, mk_dt(9), 1'b0, 6'd0,  4'b0100});
        tbl.push_back('{4'b1111, RG, mk_dt(10), 1'b0, 6'd0, 4'b1000});
        tbl.push_back('{4'b0010, RG, mk_dt(11), 1'b0, 6'd0, 4'b0010});
        tbl.push_back('{4'b1001, RG, mk_dt(12), 1'b0, 6'd0, 4'b1000});
        tbl.push_back('{4'b0001, RG, mk_dt(13), 1'b0, 6'd0, 4'b0001});
        tbl.push_back('{4'b0011, RG, mk_dt(14), 1'b0, 6'd0, 4'b0010});
        tbl.push_back('{4'b0100, {6'd13, 6'd0, 6'd11, 6'd10}, {16'h0, 16'hFFFF, 32'h0}, 1'b1, 6'd0, 4'b0100});
        tbl.push_back('{4'b0000, RG, mk_dt(16), 1'b1, 6'd20, 4'b0000});
        tbl.push_back('{4'b0000, RG, mk_dt(17), 1'b1, 6'd21, 4'b0000});
        tbl.push_back('{4'b0000, RG, mk_dt(18), 1'b1, 6'd22, 4'b0000});

        for (int k = 0; k < tbl.size(); k++) begin
            if (k == 3) for (int i = 0; i < 4; i++) gcnt[i] = 0;
            apply(tbl[k].v, tbl[k].rg, tbl[k].dt, tbl[k].cv, tbl[k].cr, tbl[k].er, $sformatf("vec%0d", k));
            if (k == 10) begin
                for (int i = 0; i < 4; i++) chk($sformatf("fair cnt%0d", i), 64'(gcnt[i]), 64'd2);
            end
        end
        chk("claims 20-22", 64'(busy[22:20]), 64'b111);

        // Claim vs clear collision on reg 7 (ptr is 3 here)
        apply(4'b0000, RG, mk_dt(30), 1'b1, 6'd7, 4'b0000, "coll claim");
        chk("coll busy7 set", 64'(busy[7]), 64'd1);
        apply(4'b1000, {6'd7, 6'd12, 6'd11, 6'd10}, mk_dt(31), 1'b1, 6'd7, 4'b1000, "coll both");
        chk("coll busy7 kept", 64'(busy[7]), 64'd1);
        apply(4'b0001, {6'd13, 6'd12, 6'd11, 6'd7}, mk_dt(32), 1'b0, 6'd0, 4'b0001, "coll clear");
        chk("coll busy7 clr", 64'(busy[7]), 64'd0);

        // Asynchronous reset between edges while a write is in flight (ptr is 1 here)
        req_valid   = 4'b1111;
        req_reg     = RG;
        req_data    = mk_dt(40);
        claim_valid = 1'b1;
        claim_reg   = 6'd30;
        #1;
        chk("pre-rst ready", 64'(req_ready), 64'b0010);
        @(posedge clk);
        #1;
        chk("pre-rst rf_we", 64'(rf_we), 64'd1);
        chk("pre-rst busy30", 64'(busy[30]), 64'd1);
        req_valid   = 4'b0000;
        claim_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst rf_we", 64'(rf_we), 64'd0);
        chk("arst busy", 64'(busy), 64'd0);
        chk("arst waddr", 64'(rf_waddr), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        busy_m    = '0;
        last_addr = '0;
        last_data = '0;
        @(posedge clk);
        #1;
        apply(4'b1100, RG, mk_dt(50), 1'b0, 6'd0, 4'b0100, "post-rst");
        apply(4'b0011, RG, mk_dt(51), 1'b0, 6'd0, 4'b0001, "post-rst2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter and busy-bit scoreboard for the single write port of `regfile` in the out-of-order MIPS core. Up to NREQ functional units present results. The block grants one per cycle in round-robin order and drives `regfile`'s `we_1`/`write_reg1`/`write_reg1_data` from registered outputs. It also keeps a per-register busy bit that issue logic sets when a destination is claimed and that write-back clears, so issue can detect RAW hazards.

## Interface
Parameters:
- WIDTH, 16, data width; matches `regfile` WIDTH
- DEPTH, 64, number of architectural registers; AW = $clog2(DEPTH)
- NREQ, 4, number of write-back requesters

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  requester i has a result pending
- req_reg  in  NREQ*AW  destination register of requester i, packed as slice [i*AW +: AW]
- req_data  in  NREQ*WIDTH  result of requester i, packed as slice [i*WIDTH +: WIDTH]
- req_ready  out  NREQ  one-hot grant; the request is consumed this cycle
- claim_valid  in  1  issue stage claims a destination register
- claim_reg  in  AW  register being claimed
- busy  out  DEPTH  scoreboard; bit r = 1 means register r has an outstanding producer
- rf_we  out  1  to `regfile` `we_1`
- rf_waddr  out  AW  to `regfile` `write_reg1`
- rf_wdata  out  WIDTH  to `regfile` `write_reg1_data`

## Operation
- Handshake: a requester raises req_valid with req_reg and req_data stable. It must hold all three until it sees req_ready=1 in the same cycle. Transfer occurs when req_valid and req_ready are both 1.
- req_ready is combinational from req_valid and the priority pointer. At most one bit is set. It is never set for a requester whose req_valid is 0.
- Round-robin arbitration:
  - A pointer ptr (width $clog2(NREQ), reset 0) names the highest-priority requester.
  - The grant goes to the first valid requester scanning ptr, ptr+1, … modulo NREQ.
  - After a grant to requester g, ptr becomes (g+1) mod NREQ.
  - With no grant, ptr holds.
- Write stage:
  - A grant to requester g registers rf_we=1, rf_waddr=req_reg[g], rf_wdata=req_data[g].
  - With no grant, rf_we=0 and rf_waddr/rf_wdata hold their last values.
- Register 0:
  - A request to reg 0 is granted and consumed normally, but rf_we is forced to 0.
  - busy[0] is constant 0, and claims of reg 0 are ignored.
- Scoreboard:
  - A claim sets busy[claim_reg].
  - A granted write-back clears busy[req_reg[g]] at the same edge the write is registered.
  - If a claim and a clear hit the same register in the same cycle, the claim wins and the bit stays 1, because the new producer supersedes the old one.
- The block does not check for duplicate in-flight producers to one register. Issue logic must avoid them.

## Timing
- Reset (asynchronous assert): rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, ptr=0. req_ready then depends only on req_valid with ptr=0.
- Latency:
  - Grant in cycle N, then rf_we/addr/data valid in cycle N+1, then `regfile` is updated at the end of N+1.
  - The busy bit clears at the end of cycle N, so an issue check in N+1 sees it clear. Downstream bypass covers the one-cycle gap before the register file holds the value.
- Throughput: one write-back per cycle, sustained. With all NREQ requesters valid, each is granted exactly once in any NREQ consecutive cycles.
- Reset asserted mid-operation: outstanding grants are lost and busy clears. Requesters must also be reset.
- Back-to-back claims of different registers in consecutive cycles are all recorded.

## Structure
- A shared package holds the AW derivation helper and the zero-register constant (REG_ZERO = 0), which issue logic also uses.
- One sub-module is natural: `rr_arbiter` (NREQ request bits in, one-hot grant plus encoded index out, internal ptr). It is reusable for the issue-port arbiter.
- The scoreboard and output registers stay in wb_arbiter.

## Test plan
- Single request: after reset, req_valid=4'b0001, req_reg[0]=5, data=16'h1234 → req_ready=4'b0001 in cycle N; rf_we=1, rf_waddr=5, rf_wdata=16'h1234 in N+1; rf_we=0 in N+2.
- Fairness: all four valid and held for 8 cycles → grant order 0,1,2,3,0,1,2,3; each requester gets 2 grants.
- Pointer skip: ptr=2 and only requesters 0 and 3 valid → requester 3 granted, then requester 0 next cycle, then ptr=1.
- Register 0: request to reg 0 with data 16'hFFFF → req_ready=1, rf_we stays 0; claim of reg 0 → busy[0] stays 0.
- Scoreboard collision: busy[7]=1, then in one cycle claim reg 7 and grant a write-back to reg 7 → busy[7]=1 afterwards. A later write-back to reg 7 with no claim → busy[7]=0.
- Async reset mid-stream: assert rst_n=0 between clock edges while rf_we=1 and busy≠0 → rf_we=0 and busy=0 immediately, without waiting for a clock edge. After release, the first grant goes to the lowest-index valid requester.
